// File: rtl/writeback_regfile.sv
// writeback_regfile: write-back end of the Y86-64 pipeline.
// Holds the W pipeline register (stall/bubble) and the 16x64 register file
// read by decode. Status is tracked with a sticky halt.
// Optional feature macro: WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
module writeback_regfile #(
  parameter int DATA_W = 64,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic              W_stall,
  input  logic              W_bubble,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] rvalA,
  output logic [DATA_W-1:0] rvalB,
  output logic [2:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [3:0]        W_dstE,
  output logic [DATA_W-1:0] W_valE,
  output logic [3:0]        W_dstM,
  output logic [DATA_W-1:0] W_valM,
  output logic [2:0]        stat,
  output logic              halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retired
`endif
);

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [3:0] INOP  = 4'd1;
  localparam logic [3:0] RNONE = 4'd15;

  logic [DATA_W-1:0] regFile [NREG];
  logic              commitOk;
  logic              freezeW;

  // W contents retire only while the pipeline is healthy and not yet stopped.
  assign commitOk = (W_stat == SAOK) && !halted;

  // A faulting status sitting in W stops the W register at the same edge that
  // raises halted, so stat keeps reporting the fault code.
  assign freezeW = halted || (W_stat != SAOK);

  assign stat = W_stat;

  // W pipeline register: reset > frozen > bubble > stall > load from M.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      W_stat  <= SAOK;
      W_icode <= INOP;
      W_dstE  <= RNONE;
      W_valE  <= '0;
      W_dstM  <= RNONE;
      W_valM  <= '0;
    end else if (freezeW) begin
      W_stat  <= W_stat;
    end else if (W_bubble) begin
      W_stat  <= SAOK;
      W_icode <= INOP;
      W_dstE  <= RNONE;
      W_valE  <= '0;
      W_dstM  <= RNONE;
      W_valM  <= '0;
    end else if (!W_stall) begin
      W_stat  <= M_stat;
      W_icode <= M_icode;
      W_dstE  <= M_dstE;
      W_valE  <= M_valE;
      W_dstM  <= M_dstM;
      W_valM  <= m_valM;
    end
  end

  // Sticky halt: any non-AOK status reaching W stops the processor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (W_stat != SAOK) begin
      halted <= 1'b1;
    end
  end

  // Register file commit; the M write comes last so it wins on dstE==dstM (popq %rsp).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        if (i == NREG - 1) begin
          regFile[i] <= '0;
        end else begin
          regFile[i] <= DATA_W'(i);
        end
      end
    end else if (commitOk) begin
      if (W_dstE != RNONE) begin
        regFile[W_dstE] <= W_valE;
      end
      if (W_dstM != RNONE) begin
        regFile[W_dstM] <= W_valM;
      end
    end
  end

  // Decode read ports; RNONE always reads as zero, no write-through.
  always_comb begin
    rvalA = '0;
    rvalB = '0;
    if (srcA != RNONE) begin
      rvalA = regFile[srcA];
    end
    if (srcB != RNONE) begin
      rvalB = regFile[srcB];
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Count real instructions (not NOPs or bubbles) as they retire from W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (commitOk && (W_icode != INOP)) begin
      retired <= retired + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: self-checking bench for writeback_regfile.
// Directed scenarios plus randomized traffic compared against a behavioural model.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic [3:0]  M_dstE;
  logic [63:0] M_valE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] rvalA;
  logic [63:0] rvalB;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [63:0] W_valE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valM;
  logic [2:0]  stat;
  logic        halted;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired;
`endif

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state
  logic [2:0]  mStat;
  logic [3:0]  mIcode;
  logic [3:0]  mDstE;
  logic [63:0] mValE;
  logic [3:0]  mDstM;
  logic [63:0] mValM;
  logic [63:0] mReg [16];
  logic        mHalted;
  logic [63:0] mRetired;

  writeback_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_stall(W_stall), .W_bubble(W_bubble),
    .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .stat(stat), .halted(halted)
`ifdef WB_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance the model by one clock edge using the current inputs
  task automatic modelStep();
    logic bubbleLoad;
    if (!rst_n) begin
      mStat = 3'd1; mIcode = 4'd1; mDstE = 4'd15; mValE = '0; mDstM = 4'd15; mValM = '0;
      for (int i = 0; i < 15; i++) mReg[i] = 64'(i);
      mReg[15] = '0;
      mHalted = 1'b0;
      mRetired = '0;
    end else begin
      if (mStat == 3'd1 && !mHalted) begin
        if (mDstE != 4'd15) mReg[mDstE] = mValE;
        if (mDstM != 4'd15) mReg[mDstM] = mValM;
        if (mIcode != 4'd1) mRetired = mRetired + 64'd1;
      end
      if (mHalted || mStat != 3'd1) begin
        mHalted = 1'b1;
      end else begin
        bubbleLoad = W_bubble;
        if (bubbleLoad) begin
          mStat = 3'd1; mIcode = 4'd1; mDstE = 4'd15; mValE = '0; mDstM = 4'd15; mValM = '0;
        end else if (!W_stall) begin
          mStat = M_stat; mIcode = M_icode; mDstE = M_dstE; mValE = M_valE;
          mDstM = M_dstM; mValM = m_valM;
        end
      end
    end
  endtask

  // One clock edge for both the model and the DUT; outputs settle 1 ns later
  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  // Drive M-stage inputs plus stall/bubble, then clock once
  task automatic applyStimulus(input logic [2:0] st, input logic [3:0] ic,
                               input logic [3:0] dE, input logic [63:0] vE,
                               input logic [3:0] dM, input logic [63:0] vM,
                               input logic stl, input logic bub);
    M_stat = st; M_icode = ic; M_dstE = dE; M_valE = vE;
    M_dstM = dM; m_valM = vM; W_stall = stl; W_bubble = bub;
    tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(3'd1, 4'd1, 4'd15, 64'd0, 4'd15, 64'd0, 1'b0, 1'b0);
    applyStimulus(3'd1, 4'd1, 4'd15, 64'd0, 4'd15, 64'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    srcA = 4'd3; srcB = 4'd15;
    #1;
    testCount++; if (W_dstE !== 4'd15) begin failCount++; $display("[TB] FAIL reset_W_dstE got %0d want 15", W_dstE); end
    testCount++; if (W_icode !== 4'd1) begin failCount++; $display("[TB] FAIL reset_W_icode got %0d want 1", W_icode); end
    testCount++; if (stat !== 3'd1) begin failCount++; $display("[TB] FAIL reset_stat got %0d want 1", stat); end
    testCount++; if (halted !== 1'b0) begin failCount++; $display("[TB] FAIL reset_halted got %0b want 0", halted); end
    testCount++; if (rvalA !== 64'd3) begin failCount++; $display("[TB] FAIL reset_read3 got %0h want 3", rvalA); end
    testCount++; if (rvalB !== 64'd0) begin failCount++; $display("[TB] FAIL reset_read15 got %0h want 0", rvalB); end
  endtask

  task automatic test_latency();
    srcA = 4'd2;
    applyStimulus(3'd1, 4'd3, 4'd2, 64'h55, 4'd15, 64'd0, 1'b0, 1'b0);
    testCount++; if (W_valE !== 64'h55) begin failCount++; $display("[TB] FAIL lat_W_valE got %0h want 55", W_valE); end
    testCount++; if (rvalA !== 64'd2) begin failCount++; $display("[TB] FAIL lat_no_writethrough got %0h want 2", rvalA); end
    applyStimulus(3'd1, 4'd3, 4'd7, 64'h99, 4'd15, 64'd0, 1'b0, 1'b1);
    testCount++; if (rvalA !== 64'h55) begin failCount++; $display("[TB] FAIL lat_rvalA got %0h want 55", rvalA); end
  endtask

  task automatic test_popq();
    srcA = 4'd4;
    applyStimulus(3'd1, 4'hB, 4'd4, 64'h10, 4'd4, 64'h20, 1'b0, 1'b0);
    applyStimulus(3'd1, 4'd1, 4'd15, 64'd0, 4'd15, 64'd0, 1'b0, 1'b1);
    testCount++; if (rvalA !== 64'h20) begin failCount++; $display("[TB] FAIL popq_reg4 got %0h want 20", rvalA); end
  endtask

  task automatic test_stall_bubble();
    applyStimulus(3'd1, 4'd6, 4'd6, 64'h1234, 4'd15, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd1, 4'd3, 4'd9, 64'(i + 100), 4'd8, 64'hABC, 1'b1, 1'b0);
      testCount++; if (W_dstE !== 4'd6 || W_valE !== 64'h1234 || W_dstM !== 4'd15) begin
        failCount++; $display("[TB] FAIL stall_hold got dstE=%0d valE=%0h dstM=%0d want 6/1234/15", W_dstE, W_valE, W_dstM);
      end
    end
    applyStimulus(3'd1, 4'd3, 4'd9, 64'h77, 4'd8, 64'hABC, 1'b1, 1'b1);
    testCount++; if (W_icode !== 4'd1 || W_dstE !== 4'd15) begin
      failCount++; $display("[TB] FAIL bubble_stall got icode=%0d dstE=%0d want 1/15", W_icode, W_dstE);
    end
    srcA = 4'd6; #1;
    testCount++; if (rvalA !== 64'h1234) begin failCount++; $display("[TB] FAIL stall_reg6 got %0h want 1234", rvalA); end
  endtask

  task automatic test_halt();
    doReset();
    srcA = 4'd1;
    applyStimulus(3'd4, 4'd0, 4'd1, 64'hDEAD, 4'd15, 64'd0, 1'b0, 1'b0);
    testCount++; if (W_stat !== 3'd4 || stat !== 3'd4) begin failCount++; $display("[TB] FAIL halt_W_stat got %0d/%0d want 4", W_stat, stat); end
    testCount++; if (halted !== 1'b0) begin failCount++; $display("[TB] FAIL halt_early got %0b want 0", halted); end
    applyStimulus(3'd4, 4'd0, 4'd1, 64'hDEAD, 4'd15, 64'd0, 1'b0, 1'b0);
    testCount++; if (halted !== 1'b1) begin failCount++; $display("[TB] FAIL halt_set got %0b want 1", halted); end
    testCount++; if (rvalA !== 64'd1) begin failCount++; $display("[TB] FAIL halt_reg1 got %0h want 1", rvalA); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd1, 4'd3, 4'd1, 64'h77, 4'd2, 64'h88, 1'b0, (i == 1));
      srcB = 4'd2; #1;
      testCount++; if (stat !== 3'd4 || halted !== 1'b1 || W_dstE !== 4'd1 || rvalA !== 64'd1 || rvalB !== 64'd2) begin
        failCount++; $display("[TB] FAIL halt_frozen got stat=%0d halted=%0b dstE=%0d r1=%0h r2=%0h want 4/1/1/1/2", stat, halted, W_dstE, rvalA, rvalB);
      end
    end
    doReset();
    testCount++; if (halted !== 1'b0 || stat !== 3'd1) begin failCount++; $display("[TB] FAIL halt_reset got halted=%0b stat=%0d want 0/1", halted, stat); end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire();
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(3'd1, 4'd3, 4'(i + 8), 64'(i), 4'd15, 64'd0, 1'b0, 1'b0);
    applyStimulus(3'd1, 4'd3, 4'd15, 64'd0, 4'd15, 64'd0, 1'b0, 1'b1);
    applyStimulus(3'd1, 4'd3, 4'd15, 64'd0, 4'd15, 64'd0, 1'b0, 1'b1);
    applyStimulus(3'd4, 4'd0, 4'd15, 64'd0, 4'd15, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(3'd1, 4'd3, 4'd5, 64'd0, 4'd15, 64'd0, 1'b0, 1'b0);
    testCount++; if (retired !== 64'd5) begin failCount++; $display("[TB] FAIL retire_count got %0d want 5", retired); end
  endtask
`endif

  task automatic test_random();
    logic [2:0] st;
    doReset();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      st = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      applyStimulus(st, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                    4'($urandom_range(0, 15)), {$urandom, $urandom},
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
      testCount++;
      if (W_stat !== mStat || W_icode !== mIcode || W_dstE !== mDstE || W_valE !== mValE ||
          W_dstM !== mDstM || W_valM !== mValM || stat !== mStat || halted !== mHalted) begin
        failCount++;
        $display("[TB] FAIL rand_wreg cyc %0d got stat=%0d ic=%0d dE=%0d vE=%0h dM=%0d vM=%0h h=%0b want %0d/%0d/%0d/%0h/%0d/%0h/%0b",
                 n, W_stat, W_icode, W_dstE, W_valE, W_dstM, W_valM, halted,
                 mStat, mIcode, mDstE, mValE, mDstM, mValM, mHalted);
      end
      testCount++;
      if (rvalA !== ((srcA == 4'd15) ? 64'd0 : mReg[srcA]) || rvalB !== ((srcB == 4'd15) ? 64'd0 : mReg[srcB])) begin
        failCount++;
        $display("[TB] FAIL rand_read cyc %0d got A=%0h B=%0h want A=%0h B=%0h", n, rvalA, rvalB,
                 (srcA == 4'd15) ? 64'd0 : mReg[srcA], (srcB == 4'd15) ? 64'd0 : mReg[srcB]);
      end
`ifdef WB_RETIRE_CNT_EN
      testCount++;
      if (retired !== mRetired) begin
        failCount++; $display("[TB] FAIL rand_retired cyc %0d got %0d want %0d", n, retired, mRetired);
      end
`endif
    end
  endtask

  // Run all scenarios in order, then report
  initial begin
    rst_n = 1'b0; M_stat = 3'd1; M_icode = 4'd1; M_dstE = 4'd15; M_valE = '0;
    M_dstM = 4'd15; m_valM = '0; W_stall = 1'b0; W_bubble = 1'b0; srcA = 4'd0; srcB = 4'd0;
    mStat = 3'd1; mIcode = 4'd1; mDstE = 4'd15; mValE = '0; mDstM = 4'd15; mValM = '0;
    mHalted = 1'b0; mRetired = '0;
    for (int i = 0; i < 16; i++) mReg[i] = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_popq();
    test_stall_bubble();
    test_halt();
`ifdef WB_RETIRE_CNT_EN
    test_retire();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
